// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared funct codes, sequencer states and decode helper
package mul_div_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    // The four multi-cycle functs share the 0110xx prefix.
    function automatic logic is_muldiv(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/mul_div_seq_if.sv
// mul_div_seq_if: request/result bundle between decode and the mul/div sequencer
interface mul_div_seq_if #(parameter int WIDTH = 32);
    logic             start_i;
    logic [5:0]       funct_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic             stall_o;
    logic             div_zero_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport slave (
        input  start_i, funct_i, src1_i, src2_i,
        output busy_o, done_o, stall_o, div_zero_o, hi_o, lo_o
    );

    modport master (
        output start_i, funct_i, src1_i, src2_i,
        input  busy_o, done_o, stall_o, div_zero_o, hi_o, lo_o
    );
endinterface

// File: rtl/mul_div_step.sv
// mul_div_step: one iteration of shift-add multiply or restoring divide
module mul_div_step #(parameter int WIDTH = 32) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Multiply keeps the carry so the right shift never loses a product bit;
    // divide subtracts only when the shifted remainder covers the divisor, and
    // when it does the difference is below the divisor, so W bits suffice.
    always_comb begin
        sum      = {1'b0, acc_hi_i} + {1'b0, operand_i & {WIDTH{acc_lo_i[0]}}};
        rem_sh   = {acc_hi_i, acc_lo_i[WIDTH-1]};
        ge       = rem_sh >= {1'b0, operand_i};
        diff     = rem_sh[WIDTH-1:0] - operand_i;
        acc_hi_o = div_i ? (ge ? diff : rem_sh[WIDTH-1:0]) : sum[WIDTH:1];
        acc_lo_o = div_i ? {acc_lo_i[WIDTH-2:0], ge} : {sum[0], acc_lo_i[WIDTH-1:1]};
    end
endmodule

// File: rtl/mul_div_seq.sv
// mul_div_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer holding results in HI/LO
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mul_div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             sign1_q, sign1_d;
    logic             sign2_q, sign2_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic             is_div;
    logic             s1, s2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .div_i     (is_div),
        .acc_hi_i  (acc_hi_q),
        .acc_lo_i  (acc_lo_q),
        .operand_i (opnd_q),
        .acc_hi_o  (step_hi),
        .acc_lo_o  (step_lo)
    );

    // Sign/magnitude of the raw operands parked in acc_hi/acc_lo during PREP,
    // and the signed fix-up of the finished unsigned result during FIX.
    always_comb begin
        is_div   = op_q[1];
        s1       = ~op_q[0] & acc_hi_q[WIDTH-1];
        s2       = ~op_q[0] & acc_lo_q[WIDTH-1];
        mag1     = s1 ? -acc_hi_q : acc_hi_q;
        mag2     = s2 ? -acc_lo_q : acc_lo_q;
        prod_neg = -{acc_hi_q, acc_lo_q};
        fix_hi   = is_div ? (sign1_q ? -acc_hi_q : acc_hi_q)
                          : (sign1_q ^ sign2_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi_q);
        fix_lo   = is_div ? (sign1_q ^ sign2_q ? -acc_lo_q : acc_lo_q)
                          : (sign1_q ^ sign2_q ? prod_neg[WIDTH-1:0] : acc_lo_q);
    end

    // Next-state and datapath control; HI/LO only move on the FIX->DONE edge.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        dz_d       = dz_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: if (bus.start_i && is_muldiv(bus.funct_i)) begin
                state_d  = PREP;
                op_d     = bus.funct_i[1:0];
                acc_hi_d = bus.src1_i;
                acc_lo_d = bus.src2_i;
            end
            PREP: begin
                state_d  = RUN;
                sign1_d  = s1;
                sign2_d  = s2;
                dz_d     = is_div & ~|acc_lo_q;
                acc_hi_d = '0;
                acc_lo_d = is_div ? mag1 : mag2;
                opnd_d   = is_div ? mag2 : mag1;
                cnt_d    = CW'(WIDTH - 1);
            end
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q - CW'(1);
                state_d  = cnt_q == '0 ? FIX : RUN;
            end
            FIX: begin
                state_d    = DONE;
                hi_d       = fix_hi;
                lo_d       = fix_lo;
                div_zero_d = dz_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and work registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            dz_q       <= 1'b0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            dz_q       <= dz_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Stall covers the request cycle too, so the pipeline freezes before PREP.
    always_comb begin
        bus.busy_o     = state_q != IDLE;
        bus.done_o     = state_q == DONE;
        bus.stall_o    = (bus.busy_o & ~bus.done_o) |
                         (state_q == IDLE & bus.start_i & is_muldiv(bus.funct_i));
        bus.div_zero_o = div_zero_q;
        bus.hi_o       = hi_q;
        bus.lo_o       = lo_q;
    end
endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: scoreboard bench for the mul/div sequencer
module tb_mul_div_seq;
    import mul_div_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    logic [64:0] sb[$];

    mul_div_seq_if #(.WIDTH(32)) bus ();

    mul_div_seq #(.WIDTH(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (f)
            FUNCT_MULT:  begin p = sa * sbv; return {1'b0, p}; end
            FUNCT_MULTU: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            FUNCT_DIV: begin
                if (b == 0) return {1'b1, a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
                q = sa / sbv;
                r = sa % sbv;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (bus.done_o) begin
            logic [64:0] e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi", {32'b0, bus.hi_o}, {32'b0, e[63:32]});
                check("lo", {32'b0, bus.lo_o}, {32'b0, e[31:0]});
                check("div_zero", {63'b0, bus.div_zero_o}, {63'b0, e[64]});
            end
        end
    end

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [64:0] e);
        int n, st;
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.funct_i = f;
        bus.src1_i  = a;
        bus.src2_i  = b;
        sb.push_back(e);
        #1 check("stall_req", {63'b0, bus.stall_o}, 64'd1);
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
        n  = 0;
        st = 0;
        do begin
            @(negedge clk_i);
            n++;
            st += int'(bus.stall_o);
        end while (!bus.done_o && n < 60);
        check("latency", 64'(n), 64'd35);
        check("stall_cycles", 64'(st), 64'd34);
    endtask

    initial begin
        int n, idle_n, d0;
        logic busy37;
        logic [5:0] fl[4];
        bus.start_i = 1'b0;
        bus.funct_i = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", {63'b0, bus.busy_o}, 64'd0);
        check("rst_done", {63'b0, bus.done_o}, 64'd0);
        check("rst_stall", {63'b0, bus.stall_o}, 64'd0);
        check("rst_dz", {63'b0, bus.div_zero_o}, 64'd0);
        check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        rst_i = 1'b0;

        run_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001});
        run_op(FUNCT_MULT, -32'sd3, 32'd7, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
        run_op(FUNCT_MULT, 32'h80000000, 32'h80000000, {1'b0, 32'h40000000, 32'h0});
        run_op(FUNCT_DIV, -32'sd7, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op(FUNCT_DIVU, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
        run_op(FUNCT_DIVU, 32'd5, 32'd0, {1'b1, 32'd5, 32'hFFFFFFFF});
        run_op(FUNCT_DIVU, 32'd6, 32'd3, {1'b0, 32'd0, 32'd2});
        run_op(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'd0, 32'h80000000});
        run_op(FUNCT_DIV, -32'sd5, 32'd0, {1'b1, 32'hFFFFFFFB, 32'd1});

        fl = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
        for (int i = 0; i < 8; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            f = fl[i % 4];
            a = $urandom;
            b = $urandom;
            if (i >= 4) b = b >> $urandom_range(31, 0);
            if (b == 0) b = 32'd9;
            run_op(f, a, b, model(f, a, b));
        end

        // start held for 40 cycles: one completion in the window, re-accept at k+36
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.funct_i = FUNCT_MULT;
        bus.src1_i  = 32'd5;
        bus.src2_i  = 32'd6;
        sb.push_back({1'b0, 32'd0, 32'd30});
        sb.push_back({1'b0, 32'd0, 32'd30});
        d0 = done_cnt;
        idle_n = 0;
        busy37 = 1'b0;
        @(posedge clk_i);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk_i);
            if (n == 40) bus.start_i = 1'b0;
            if (!bus.busy_o && idle_n == 0) idle_n = n;
            if (n == 37) busy37 = bus.busy_o;
        end
        #1;
        check("held_done_count", 64'(done_cnt - d0), 64'd1);
        check("held_idle_cycle", 64'(idle_n), 64'd36);
        check("held_reaccept", {63'b0, busy37}, 64'd1);
        n = 0;
        while (done_cnt - d0 < 2 && n < 60) begin
            @(negedge clk_i);
            #1 n++;
        end
        check("held_second_done", 64'(done_cnt - d0), 64'd2);

        // ADD funct never stalls nor starts
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.funct_i = 6'b100000;
        #1 check("add_stall", {63'b0, bus.stall_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("add_stall", {63'b0, bus.stall_o}, 64'd0);
            check("add_busy", {63'b0, bus.busy_o}, 64'd0);
        end
        bus.start_i = 1'b0;

        // reset at k+10 of a DIV aborts it
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.funct_i = FUNCT_DIV;
        bus.src1_i  = -32'sd100;
        bus.src2_i  = 32'd7;
        @(posedge clk_i);
        #1 bus.start_i = 1'b0;
        for (n = 1; n <= 10; n++) @(negedge clk_i);
        rst_i = 1'b1;
        d0 = done_cnt;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_busy", {63'b0, bus.busy_o}, 64'd0);
        check("abort_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        repeat (40) @(negedge clk_i);
        #1 check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_op(FUNCT_MULTU, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12});

        repeat (2) @(negedge clk_i);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
